// File: rtl/dio_pkg.sv
// Shared definitions for the DIO target: FSM state type, IO map constants and status bit positions.
package dio_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } dio_state_t;

    localparam int          NUM_SCRATCH      = 8;
    localparam int          STATUS_W         = 2;
    localparam logic [15:0] IO_SCRATCH_LAST  = 16'h0007;
    localparam logic [15:0] IO_STATUS_ADDR   = 16'h0008;
    localparam logic [15:0] IO_COUNTER_ADDR  = 16'h0009;

    localparam int STAT_TIMEOUT_BIT   = 0;
    localparam int STAT_COLLISION_BIT = 1;

    function automatic logic is_scratch(input logic [15:0] addr);
        return addr <= IO_SCRATCH_LAST;
    endfunction

endpackage

// File: rtl/dio_io_regs.sv
// IO-space register file: eight scratch registers, sticky status (write-1-to-clear) and a free-running counter.
module dio_io_regs
    import dio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] io_addr,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        set_timeout,
    input  logic        set_collision,
    output logic [15:0] rd_data
);

    logic [15:0]         scratch_q [NUM_SCRATCH];
    logic [STATUS_W-1:0] status_reg;
    logic [STATUS_W-1:0] status_next;
    logic [STATUS_W-1:0] status_clr;
    logic [15:0]         count_reg;
    logic [15:0]         count_next;
    logic                wr_scratch;
    logic                wr_status;
    logic                wr_count;

    assign wr_scratch = wr_en && is_scratch(io_addr);
    assign wr_status  = wr_en && (io_addr == IO_STATUS_ADDR);
    assign wr_count   = wr_en && (io_addr == IO_COUNTER_ADDR);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
            logic [15:0] value_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    value_reg <= '0;
                end else if (wr_scratch && (io_addr[2:0] == 3'(gi))) begin
                    value_reg <= wr_data;
                end
            end

            assign scratch_q[gi] = value_reg;
        end
    endgenerate

    // A set event in the same cycle as a clear keeps the bit set.
    always_comb begin
        status_clr  = wr_status ? wr_data[STATUS_W-1:0] : '0;
        status_next = status_reg & ~status_clr;
        if (set_timeout) begin
            status_next[STAT_TIMEOUT_BIT] = 1'b1;
        end
        if (set_collision) begin
            status_next[STAT_COLLISION_BIT] = 1'b1;
        end
    end

    assign count_next = wr_count ? wr_data : (count_reg + 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_reg <= '0;
            count_reg  <= '0;
        end else begin
            status_reg <= status_next;
            count_reg  <= count_next;
        end
    end

    // Counter reads return the value the counter holds in the cycle the
    // captured read data becomes visible, so it tracks live time.
    always_comb begin
        rd_data = '0;
        if (is_scratch(io_addr)) begin
            rd_data = scratch_q[io_addr[2:0]];
        end else if (io_addr == IO_STATUS_ADDR) begin
            rd_data = {{(16 - STATUS_W){1'b0}}, status_reg};
        end else if (io_addr == IO_COUNTER_ADDR) begin
            rd_data = count_next;
        end
    end

endmodule

// File: rtl/dio_target.sv
// CPU data/IO target: IO requests served from the local register file, data requests
// forwarded to an external memory port with a bounded wait and error-data abort.
module dio_target
    import dio_pkg::*;
#(
    parameter int          MEM_TIMEOUT = 255,
    parameter logic [15:0] ERR_DATA    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_ren,
    input  logic        data_wren,
    input  logic        IO_ren,
    input  logic        IO_wren,
    input  logic [31:0] data_address,
    input  logic [15:0] IO_address,
    input  logic [15:0] DIO_out,
    output logic [15:0] DIO_in,
    output logic        data_hazard,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    dio_state_t        state_reg;
    dio_state_t        state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [15:0]       dio_in_reg;
    logic              mem_we_reg;
    logic [31:0]       mem_addr_reg;
    logic [15:0]       mem_wdata_reg;

    logic              data_req;
    logic              io_idle;
    logic              io_ren_ok;
    logic              io_wren_ok;
    logic              collision;
    logic              timeout;
    logic [15:0]       io_rdata;

    assign data_req   = data_ren | data_wren;
    assign io_idle    = (state_reg == ST_IDLE) && !data_req;
    assign io_ren_ok  = io_idle && IO_ren;
    assign io_wren_ok = io_idle && IO_wren;
    assign collision  = (state_reg == ST_IDLE) && data_req && (IO_ren || IO_wren);
    assign timeout    = (state_reg == ST_ACCESS) && !mem_ack && (wait_cnt_reg == WAIT_LAST);

    dio_io_regs u_io_regs (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_addr      (IO_address),
        .wr_en        (io_wren_ok),
        .wr_data      (DIO_out),
        .set_timeout  (timeout),
        .set_collision(collision),
        .rd_data      (io_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mem_req     = 1'b0;
        data_hazard = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (data_req) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_req     = 1'b1;
                data_hazard = 1'b1;
                if (mem_ack || timeout) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A simultaneous data_ren/data_wren is a write, which data_wren alone decides.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg  <= '0;
            dio_in_reg    <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (data_req) begin
                        mem_addr_reg  <= data_address;
                        mem_wdata_reg <= DIO_out;
                        mem_we_reg    <= data_wren;
                        wait_cnt_reg  <= '0;
                    end else if (io_ren_ok) begin
                        dio_in_reg <= io_rdata;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        if (!mem_we_reg) begin
                            dio_in_reg <= mem_rdata;
                        end
                    end else if (timeout) begin
                        if (!mem_we_reg) begin
                            dio_in_reg <= ERR_DATA;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign DIO_in    = dio_in_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dio_target.sv
// Directed bench for dio_target: table of IO vectors plus hand-written memory-access sequences.
module tb_dio_target;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_ren, data_wren, IO_ren, IO_wren;
    logic [31:0] data_address;
    logic [15:0] IO_address, DIO_out, DIO_in;
    logic        data_hazard, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dio_target #(
        .MEM_TIMEOUT(4),
        .ERR_DATA   (16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_ren    (data_ren),
        .data_wren   (data_wren),
        .IO_ren      (IO_ren),
        .IO_wren     (IO_wren),
        .data_address(data_address),
        .IO_address  (IO_address),
        .DIO_out     (DIO_out),
        .DIO_in      (DIO_in),
        .data_hazard (data_hazard),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    typedef struct {
        logic        ren;
        logic        wren;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_dio;
    } io_vec_t;

    io_vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        data_ren  = 1'b0;
        data_wren = 1'b0;
        IO_ren    = 1'b0;
        IO_wren   = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic io_op(input logic ren, input logic wren, input logic [15:0] addr,
                         input logic [15:0] wdata);
        IO_ren     = ren;
        IO_wren    = wren;
        IO_address = addr;
        DIO_out    = wdata;
        step();
        clear_inputs();
    endtask

    initial begin
        rst_n        = 1'b0;
        clear_inputs();
        data_address = '0;
        IO_address   = '0;
        DIO_out      = '0;
        mem_rdata    = '0;

        //             ren   wren  addr     wdata    exp DIO_in
        vecs[0]  = '{1'b0, 1'b1, 16'h0000, 16'h1111, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 16'h0007, 16'h7777, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111};
        vecs[3]  = '{1'b1, 1'b0, 16'h0007, 16'h0000, 16'h7777};
        vecs[4]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 16'h0003, 16'hBEEF, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'hBEEF};
        vecs[7]  = '{1'b0, 1'b1, 16'h0100, 16'hAAAA, 16'hBEEF};
        vecs[8]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, 16'h0007, 16'h0000, 16'h7777};
        vecs[10] = '{1'b1, 1'b0, 16'h0008, 16'h0000, 16'h0000};
        vecs[11] = '{1'b1, 1'b0, 16'h000A, 16'h0000, 16'h0000};

        step();
        step();
        check("rst_dio_in", 32'(DIO_in), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_hazard", 32'(data_hazard), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            io_op(vecs[i].ren, vecs[i].wren, vecs[i].addr, vecs[i].wdata);
            $display("vec %0d ren=%0b wren=%0b addr=%h wdata=%h DIO_in=%h hazard=%0b",
                     i, vecs[i].ren, vecs[i].wren, vecs[i].addr, vecs[i].wdata, DIO_in, data_hazard);
            check($sformatf("vec%0d_dio_in", i), 32'(DIO_in), 32'(vecs[i].exp_dio));
            check($sformatf("vec%0d_hazard", i), 32'(data_hazard), 32'h0);
        end

        // Counter load then two back-to-back reads
        io_op(1'b0, 1'b1, 16'h0009, 16'hFFFE);
        io_op(1'b1, 1'b0, 16'h0009, 16'h0000);
        check("cnt_read1", 32'(DIO_in), 32'h0000_FFFF);
        io_op(1'b1, 1'b0, 16'h0009, 16'h0000);
        check("cnt_read2", 32'(DIO_in), 32'h0);
        $display("counter load FFFE, reads give FFFF then 0000 (DIO_in=%h)", DIO_in);

        // Data read acknowledged in the third ACCESS cycle
        data_ren     = 1'b1;
        data_address = 32'h1234_5678;
        step();
        clear_inputs();
        check("rd_mem_addr", mem_addr, 32'h1234_5678);
        check("rd_mem_we", 32'(mem_we), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("rd_req_c%0d", c), 32'(mem_req), 32'h1);
            check($sformatf("rd_hazard_c%0d", c), 32'(data_hazard), 32'h1);
            if (c == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h5A5A;
            end
            step();
        end
        clear_inputs();
        check("rd_req_done", 32'(mem_req), 32'h0);
        check("rd_hazard_done", 32'(data_hazard), 32'h0);
        check("rd_dio_in", 32'(DIO_in), 32'h5A5A);
        $display("data read 12345678 -> DIO_in=%h", DIO_in);

        // Data read with no acknowledge: abort after four ACCESS cycles
        data_ren     = 1'b1;
        data_address = 32'h0000_0100;
        step();
        clear_inputs();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("to_req_c%0d", c), 32'(mem_req), 32'h1);
            step();
        end
        check("to_req_done", 32'(mem_req), 32'h0);
        check("to_hazard_done", 32'(data_hazard), 32'h0);
        check("to_dio_in", 32'(DIO_in), 32'h0000_FFFF);
        io_op(1'b1, 1'b0, 16'h0008, 16'h0000);
        check("to_status", 32'(DIO_in), 32'h0001);
        io_op(1'b0, 1'b1, 16'h0008, 16'h0001);
        io_op(1'b1, 1'b0, 16'h0008, 16'h0000);
        check("to_status_clr", 32'(DIO_in), 32'h0000);
        $display("timeout abort, status set then cleared (DIO_in=%h)", DIO_in);

        // Data write colliding with an IO write
        io_op(1'b1, 1'b0, 16'h0003, 16'h0000);
        data_wren    = 1'b1;
        IO_wren      = 1'b1;
        data_address = 32'hCAFE_0010;
        IO_address   = 16'h0003;
        DIO_out      = 16'h1234;
        step();
        clear_inputs();
        check("col_mem_we", 32'(mem_we), 32'h1);
        check("col_mem_addr", mem_addr, 32'hCAFE_0010);
        check("col_mem_wdata", 32'(mem_wdata), 32'h1234);
        mem_ack   = 1'b1;
        mem_rdata = 16'h0BAD;
        step();
        clear_inputs();
        check("col_hazard_done", 32'(data_hazard), 32'h0);
        check("col_dio_keep", 32'(DIO_in), 32'h0000_BEEF);
        io_op(1'b1, 1'b0, 16'h0003, 16'h0000);
        check("col_io_unchanged", 32'(DIO_in), 32'h0000_BEEF);
        io_op(1'b1, 1'b0, 16'h0008, 16'h0000);
        check("col_status", 32'(DIO_in), 32'h0002);
        $display("collision data write + IO write, status=%h", DIO_in);

        // data_ren and data_wren together behave as a write
        data_ren     = 1'b1;
        data_wren    = 1'b1;
        data_address = 32'h0000_0020;
        DIO_out      = 16'h4444;
        step();
        clear_inputs();
        check("rw_mem_we", 32'(mem_we), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h9999;
        step();
        clear_inputs();
        check("rw_dio_keep", 32'(DIO_in), 32'h0002);
        $display("ren+wren treated as write, mem_we=%0b", mem_we);

        // IO write during ACCESS is ignored
        data_ren     = 1'b1;
        data_address = 32'h0000_0040;
        step();
        clear_inputs();
        io_op(1'b0, 1'b1, 16'h0005, 16'h5555);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1357;
        step();
        clear_inputs();
        check("stall_rd_dio", 32'(DIO_in), 32'h1357);
        io_op(1'b1, 1'b0, 16'h0005, 16'h0000);
        check("stall_io_ignored", 32'(DIO_in), 32'h0000);
        $display("IO write during ACCESS ignored, scratch5=%h", DIO_in);

        // mem_ack while idle
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        clear_inputs();
        check("idle_ack_dio", 32'(DIO_in), 32'h0000);
        check("idle_ack_req", 32'(mem_req), 32'h0);
        check("idle_ack_hazard", 32'(data_hazard), 32'h0);
        $display("mem_ack in IDLE ignored, DIO_in=%h", DIO_in);

        // Reset in the middle of an access, then a late acknowledge
        io_op(1'b1, 1'b0, 16'h0003, 16'h0000);
        data_ren     = 1'b1;
        data_address = 32'h0000_0080;
        step();
        clear_inputs();
        check("mrst_req_before", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_req", 32'(mem_req), 32'h0);
        check("mrst_hazard", 32'(data_hazard), 32'h0);
        check("mrst_dio_in", 32'(DIO_in), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7E7E;
        step();
        clear_inputs();
        step();
        check("mrst_late_ack_dio", 32'(DIO_in), 32'h0);
        check("mrst_late_ack_req", 32'(mem_req), 32'h0);
        check("mrst_late_ack_hazard", 32'(data_hazard), 32'h0);
        $display("reset mid-access, late ack ignored, DIO_in=%h", DIO_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
